// File: rtl/md_pad_reader.sv
// MegaDrive 3/6-button pad poller: drives TH, samples eight phases, decodes buttons.
// Optional MD_PAD_READER_DEBOUNCE_EN: publish only after two identical frames.
module md_pad_reader #(
  parameter int SETTLE_CYC = 200,
  parameter int POLL_CYC   = 107000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [5:0]  pad_in,
  output logic        th,
  output logic [11:0] buttons,
  output logic        present,
  output logic        six_btn,
  output logic        valid
);

  localparam int PW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    PH0  = 4'd1,
    PH1  = 4'd2,
    PH2  = 4'd3,
    PH3  = 4'd4,
    PH4  = 4'd5,
    PH5  = 4'd6,
    PH6  = 4'd7,
    PH7  = 4'd8,
    DONE = 4'd9
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] poll_cnt, poll_nx;
  logic [SW-1:0] set_cnt, set_nx;
  logic          th_nx;
  logic          cap;
  logic          upd;
  logic [2:0]    ph_idx;

  logic [5:0]    sync1, sync2;
  logic [5:0]    s0;
  logic [5:2]    s1;
  logic [3:0]    s5;
  logic [3:0]    s6;

  logic [11:0]   dec_btn;
  logic          dec_present;
  logic          dec_six;

  assign ph_idx = 3'(4'(state) - 4'd1);

  // pad pins are asynchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 6'h3f;
      sync2 <= 6'h3f;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      poll_cnt <= '0;
      set_cnt  <= '0;
      th       <= 1'b1;
    end else begin
      state    <= state_nx;
      poll_cnt <= poll_nx;
      set_cnt  <= set_nx;
      th       <= th_nx;
    end
  end

  always_comb begin
    state_nx = state;
    poll_nx  = poll_cnt;
    set_nx   = set_cnt;
    th_nx    = th;
    cap      = 1'b0;
    upd      = 1'b0;
    unique case (state)
      IDLE: begin
        th_nx  = 1'b1;
        set_nx = '0;
        if (!en) begin
          poll_nx = '0;
        end else if (poll_cnt == POLL_LAST) begin
          poll_nx  = '0;
          state_nx = PH0;
        end else begin
          poll_nx = poll_cnt + 1'b1;
        end
      end
      DONE: begin
        th_nx    = 1'b1;
        poll_nx  = '0;
        set_nx   = '0;
        state_nx = IDLE;
        upd      = en;
      end
      default: begin
        if (!en) begin
          state_nx = IDLE;
          th_nx    = 1'b1;
          poll_nx  = '0;
          set_nx   = '0;
        end else if (set_cnt == SET_LAST) begin
          cap      = 1'b1;
          set_nx   = '0;
          state_nx = state_t'(4'(state) + 4'd1);
          // next phase is odd (TH low) when the current one is even
          th_nx    = ph_idx[0];
        end else begin
          set_nx = set_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
      s5 <= '0;
      s6 <= '0;
    end else if (cap) begin
      unique case (1'b1)
        (ph_idx == 3'd0): s0 <= sync2;
        (ph_idx == 3'd1): s1 <= sync2[5:2];
        (ph_idx == 3'd5): s5 <= sync2[3:0];
        (ph_idx == 3'd6): s6 <= sync2[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    dec_present = (s1[3:2] == 2'b00);
    dec_six     = dec_present & (s5 == 4'b0000);
    dec_btn     = {4'b0000, ~s1[5], ~s0[5], ~s0[4], ~s1[4], ~s0[3:0]};
    if (dec_six)
      dec_btn[11:8] = {~s6[0], ~s6[1], ~s6[2], ~s6[3]};
    if (!dec_present)
      dec_btn = '0;
  end

`ifdef MD_PAD_READER_DEBOUNCE_EN
  logic [11:0] prev_btn;
  logic        prev_present;
  logic        prev_six;
  logic        same;

  assign same = (prev_btn == dec_btn) &&
                (prev_present == dec_present) &&
                (prev_six == dec_six);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_btn     <= '0;
      prev_present <= 1'b0;
      prev_six     <= 1'b0;
      buttons      <= '0;
      present      <= 1'b0;
      six_btn      <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (upd) begin
        prev_btn     <= dec_btn;
        prev_present <= dec_present;
        prev_six     <= dec_six;
        if (same) begin
          buttons <= dec_btn;
          present <= dec_present;
          six_btn <= dec_six;
          valid   <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buttons <= '0;
      present <= 1'b0;
      six_btn <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (upd) begin
        buttons <= dec_btn;
        present <= dec_present;
        six_btn <= dec_six;
        valid   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_md_pad_reader.sv
// Directed bench for md_pad_reader with a behavioural 3/6-button pad.
// Pad model follows TH and counts falling edges to emit the 6-button ID.
module tb_md_pad_reader;

  logic        clk;
  logic        reset;
  logic        en;
  logic [5:0]  pad_in;
  logic        th;
  logic [11:0] buttons;
  logic        present;
  logic        six_btn;
  logic        valid;

  logic [11:0] btn;
  logic        six_pad;
  logic        no_pad;
  int          fall_n;
  int          hi_cnt;
  logic        prev_th;

  int n_chk;
  int n_fail;
  int n;
  int vcnt;

  md_pad_reader #(
    .SETTLE_CYC(4),
    .POLL_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .pad_in(pad_in),
    .th(th),
    .buttons(buttons),
    .present(present),
    .six_btn(six_btn),
    .valid(valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    fall_n  = 0;
    hi_cnt  = 0;
    prev_th = 1'b1;
  end

  always @(negedge clk) begin
    if (prev_th && !th)
      fall_n = fall_n + 1;
    if (th)
      hi_cnt = hi_cnt + 1;
    else
      hi_cnt = 0;
    if (hi_cnt > 8)
      fall_n = 0;
    prev_th = th;
  end

  always_comb begin
    pad_in = 6'h3f;
    if (no_pad)
      pad_in = 6'h3f;
    else if (th) begin
      if (six_pad && fall_n == 3)
        pad_in = ~{btn[6], btn[5], btn[8], btn[9], btn[10], btn[11]};
      else
        pad_in = ~{btn[6], btn[5], btn[3], btn[2], btn[1], btn[0]};
    end else begin
      if (six_pad && fall_n == 3)
        pad_in = ~{btn[7], btn[4], 4'b1111};
      else if (six_pad && fall_n == 4)
        pad_in = ~{btn[7], btn[4], 4'b0000};
      else
        pad_in = ~{btn[7], btn[4], 2'b11, btn[1], btn[0]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid && cyc < 200);
    chk("valid_seen", 32'(valid), 32'd1);
  endtask

  task automatic wait_fall(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (th && cyc < 200);
    chk("th_fell", 32'(th), 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    en      = 1'b1;
    btn     = 12'h011;
    six_pad = 1'b0;
    no_pad  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_th", 32'(th), 32'd1);
    chk("rst_btn", 32'(buttons), 32'h000);
    chk("rst_present", 32'(present), 32'd0);
    chk("rst_six", 32'(six_btn), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    reset = 1'b0;

    wait_fall(n);
    chk("first_fall", 32'(n), 32'd20);
    wait_valid(n);
    chk("frame_len", 32'(n), 32'd29);
    chk("b3_btn", 32'(buttons), 32'h011);
    chk("b3_present", 32'(present), 32'd1);
    chk("b3_six", 32'(six_btn), 32'd0);
    @(negedge clk);
    chk("b3_pulse", 32'(valid), 32'd0);

    btn     = 12'h980;
    six_pad = 1'b1;
    wait_valid(n);
    chk("poll_period", 32'(n), 32'd48);
    chk("b6_btn", 32'(buttons), 32'h980);
    chk("b6_present", 32'(present), 32'd1);
    chk("b6_six", 32'(six_btn), 32'd1);

    no_pad = 1'b1;
    wait_valid(n);
    chk("np_btn", 32'(buttons), 32'h000);
    chk("np_present", 32'(present), 32'd0);
    chk("np_six", 32'(six_btn), 32'd0);

    no_pad  = 1'b0;
    six_pad = 1'b0;
    btn     = 12'h011;
    wait_valid(n);
    chk("pre_rst_btn", 32'(buttons), 32'h011);
    repeat (30) @(negedge clk);
    chk("ph3_th", 32'(th), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_th", 32'(th), 32'd1);
    chk("arst_btn", 32'(buttons), 32'h000);
    chk("arst_present", 32'(present), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(n);
    chk("post_rst_btn", 32'(buttons), 32'h011);
    chk("post_rst_present", 32'(present), 32'd1);

    repeat (38) @(negedge clk);
    chk("ph5_th", 32'(th), 32'd0);
    en = 1'b0;
    @(negedge clk);
    chk("abort_th", 32'(th), 32'd1);
    chk("abort_btn", 32'(buttons), 32'h011);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid)
        vcnt++;
    end
    chk("abort_no_valid", 32'(vcnt), 32'd0);
    chk("hold_btn", 32'(buttons), 32'h011);
    chk("hold_present", 32'(present), 32'd1);

    en = 1'b1;
    wait_fall(n);
    chk("resume_fall", 32'(n), 32'd20);
    wait_valid(n);
    chk("resume_frame", 32'(n), 32'd29);
    chk("resume_btn", 32'(buttons), 32'h011);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/md_pad_reader.md
Name: md_pad_reader

Overview:
Console-side poller for a real MegaDrive 3/6-button pad attached through the SNAC user port. It drives TH through the standard select sequence and samples the six pad data lines. It decodes the samples into a 12-bit active-high button vector, with pad-present and six-button flags. Its output feeds the P1/P2 button inputs of the controller port emulation.

Parameters:
SETTLE_CYC, 200, clock cycles each TH phase is held before sampling (must be >= 3 so the synchronizer delay is absorbed).
POLL_CYC, 107000, idle cycles between frames; must exceed the pad's 1.5 ms six-button timeout at the core clock.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
en  in  1  polling enable
pad_in  in  6  raw pad pins {C/START, B/A, RIGHT, LEFT, DOWN, UP}, active-low, asynchronous
th  out  1  TH select driven to the pad
buttons  out  12  active-high: bit0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 A, 5 B, 6 C, 7 START, 8 MODE, 9 X, 10 Y, 11 Z
present  out  1  pad detected in the last frame
six_btn  out  1  six-button ID seen in the last frame
valid  out  1  one-cycle strobe when outputs update

Behaviour:
- Reset: th=1, buttons=0, present=0, six_btn=0, valid=0, state IDLE, all counters 0. The reset is asynchronous, so th returns to 1 without waiting for a clock edge.
- pad_in passes through a 2-flop synchronizer. Samples s0..s7 are taken from the synchronized value.
- IDLE: th=1. Poll counter counts 0..POLL_CYC-1 while en=1. On the terminal count it enters PH0 and the counter clears.
- PH0..PH7: th = 1 on even phases and 0 on odd phases, updated on phase entry.
  - A settle counter runs 0..SETTLE_CYC-1.
  - On the last count the phase sample sN is captured and the state advances.
  - PH7 advances to DONE.
- DONE (1 cycle): decode, register the outputs, pulse valid=1, then return to IDLE with th=1.
- Frame length: 8*SETTLE_CYC+1 cycles. Poll period: POLL_CYC + 8*SETTLE_CYC + 1.
- Decode (each bit inverted from its active-low sample):
  - From s0: UP=~s0[0], DOWN=~s0[1], LEFT=~s0[2], RIGHT=~s0[3], B=~s0[4], C=~s0[5].
  - From s1: A=~s1[4], START=~s1[5].
  - present = (s1[3:2]==2'b00).
  - six_btn = present & (s5[3:0]==4'b0000).
  - If six_btn: Z=~s6[0], Y=~s6[1], X=~s6[2], MODE=~s6[3]. Otherwise bits 11:8 = 0.
  - If !present: buttons=0 and six_btn=0.
  - s2, s3, s4 and s7 are captured for timing only and are ignored.
- en=0:
  - In any phase the frame aborts on the next edge: th=1, state IDLE, poll counter cleared.
  - buttons, present and six_btn hold their values. No valid pulse.
  - While in IDLE, the poll counter holds at 0.
- Reset mid-frame: th=1 immediately and all outputs clear. After release the first frame starts POLL_CYC cycles later.
- Counters saturate at neither end; they are sized by $clog2 of their parameter.

Optional Feature:
MD_PAD_READER_DEBOUNCE_EN:
- Defined: the decoded frame (buttons, present, six_btn) is compared with the previous decoded frame. The outputs update and valid pulses only when two consecutive frames are identical. The previous-frame register resets to 0.
- Undefined: every completed frame updates the outputs and pulses valid.

Test Plan:
All scenarios use SETTLE_CYC=4 and POLL_CYC=16, with a behavioural pad model driving pad_in from th.
- Reset release -> th=1, buttons=0, present=0, six_btn=0, valid=0; th first falls 16+4 cycles after release.
- 3-button model, A+UP held -> after DONE: buttons=12'h011, present=1, six_btn=0, one-cycle valid.
- 6-button model, Z+MODE+START held -> buttons=12'h980, present=1, six_btn=1.
- pad_in tied 6'b111111 (no pad) -> present=0, six_btn=0, buttons=12'h000, valid still pulses.
- reset asserted during PH3 (th=0) -> th=1 with no clock edge, outputs 0; the next frame completes normally.
- en dropped during PH5 after one good frame (buttons=12'h011) -> th=1 next cycle, buttons stay 12'h011, no valid. After en returns, a full frame runs from PH0.
